// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared constants and helpers for the button debouncer
package button_pkg;

  localparam int unsigned DEFAULT_NUM_BUTTONS     = 2;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;

  // Counter width able to hold DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: synchronizer, hold counter, stable level, edge strobes
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic push_button_n,
  output logic push_button,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned     CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          sample;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // Two-flop synchronizer; resets to the released (high) pin level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], push_button_n};
    end
  end

  // Pins are active-low, so invert once here and work in "pressed = 1" terms.
  assign sample = ~sync_q[1];

  // Count consecutive disagreeing samples; accept on the last one and strobe the edge.
  always_comb begin
    cnt_d     = '0;
    stable_d  = stable_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sample != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d  = sample;
        press_d   = sample;
        release_d = ~sample;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state registers; reset discards any partial count without strobing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      stable_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign push_button   = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - array of independent debounced button channels
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = DEFAULT_NUM_BUTTONS,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] push_button_n,
  output logic [NUM_BUTTONS-1:0] push_button,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse
);

  // Channels share nothing but clock and reset.
  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clock        (clock),
      .reset        (reset),
      .push_button_n(push_button_n[gi]),
      .push_button  (push_button[gi]),
      .press_pulse  (press_pulse[gi]),
      .release_pulse(release_pulse[gi])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - randomized and directed bench with a sample-window reference model
module tb_button_debouncer;

  localparam int DC = 4;
  localparam int NB = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] push_button_n = '1;
  logic [NB-1:0] push_button;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] release_pulse;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: pins captured per edge, samples seen per edge, accepted level.
  bit            cap_q[NB][$];
  bit            samp_q[NB][$];
  logic [NB-1:0] m_stable;
  logic [NB-1:0] exp_press;
  logic [NB-1:0] exp_release;

  button_debouncer #(
    .NUM_BUTTONS    (NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .push_button_n(push_button_n),
    .push_button  (push_button),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NB; c++) begin
      cap_q[c].delete();
      samp_q[c].delete();
    end
    m_stable    = '0;
    exp_press   = '0;
    exp_release = '0;
  endtask

  // The level seen by the debounce logic at an edge is the inverted pin from two captures
  // earlier (released before that). The level flips once the last DC seen samples all
  // disagree with it.
  task automatic model_edge(input logic [NB-1:0] pins);
    bit s;
    bit all_diff;
    int n;
    exp_press   = '0;
    exp_release = '0;
    for (int c = 0; c < NB; c++) begin
      n = cap_q[c].size();
      s = (n >= 2) ? ~cap_q[c][n-2] : 1'b0;
      cap_q[c].push_back(pins[c]);
      if (cap_q[c].size() > 2) void'(cap_q[c].pop_front());
      samp_q[c].push_back(s);
      if (samp_q[c].size() > DC) void'(samp_q[c].pop_front());
      all_diff = (samp_q[c].size() == DC);
      foreach (samp_q[c][j]) if (samp_q[c][j] == m_stable[c]) all_diff = 1'b0;
      if (all_diff) begin
        m_stable[c]    = ~m_stable[c];
        exp_press[c]   = m_stable[c];
        exp_release[c] = ~m_stable[c];
      end
    end
  endtask

  task automatic step(input logic [NB-1:0] pins);
    push_button_n = pins;
    @(posedge clock);
    #1;
    model_edge(pins);
    check("level",   32'(push_button),   32'(m_stable));
    check("press",   32'(press_pulse),   32'(exp_press));
    check("release", 32'(release_pulse), 32'(exp_release));
    check("excl",    32'(press_pulse & release_pulse), 32'(0));
  endtask

  // Hold pins for n edges; report first edge (1 = capture edge) each level changes.
  task automatic hold(input logic [NB-1:0] pins, input int n,
                      output int chg0, output int chg1, output int np0, output int nr0,
                      output int np1);
    logic [NB-1:0] start;
    start = push_button;
    chg0 = 0; chg1 = 0; np0 = 0; nr0 = 0; np1 = 0;
    for (int i = 1; i <= n; i++) begin
      step(pins);
      if (chg0 == 0 && push_button[0] != start[0]) chg0 = i;
      if (chg1 == 0 && push_button[1] != start[1]) chg1 = i;
      np0 += int'(press_pulse[0]);
      nr0 += int'(release_pulse[0]);
      np1 += int'(press_pulse[1]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_level",   32'(push_button),   32'(0));
    check("rst_press",   32'(press_pulse),   32'(0));
    check("rst_release", 32'(release_pulse), 32'(0));
    @(posedge clock);
    #1;
    check("rst_hold_level", 32'(push_button | press_pulse | release_pulse), 32'(0));
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int c0, c1, p0, r0, p1;
    logic [NB-1:0] pins;
    int run_len[NB];

    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset_level",   32'(push_button),   32'(0));
    check("reset_press",   32'(press_pulse),   32'(0));
    check("reset_release", 32'(release_pulse), 32'(0));
    @(negedge clock);
    reset = 1'b0;

    hold(2'b11, 10, c0, c1, p0, r0, p1);

    // Clean press on channel 0 only.
    hold(2'b10, 20, c0, c1, p0, r0, p1);
    check("press_latency", 32'(c0), 32'(DC + 2));
    check("press_count",   32'(p0), 32'(1));
    check("ch1_quiet",     32'(c1 + p1), 32'(0));
    hold(2'b11, 12, c0, c1, p0, r0, p1);
    check("release_latency", 32'(c0), 32'(DC + 2));
    check("release_count",   32'(r0), 32'(1));
    check("release_nopress", 32'(p0), 32'(0));

    // Bounce shorter than the hold window never gets through.
    hold(2'b10, 3, c0, c1, p0, r0, p1);
    check("bounce_a", 32'(c0 + p0 + r0), 32'(0));
    hold(2'b11, 1, c0, c1, p0, r0, p1);
    hold(2'b10, 2, c0, c1, p0, r0, p1);
    check("bounce_b", 32'(c0 + p0 + r0), 32'(0));
    hold(2'b11, 10, c0, c1, p0, r0, p1);
    check("bounce_c", 32'(c0 + p0 + r0), 32'(0));

    // Bounce then settle low: latency measured from the final low capture.
    hold(2'b10, 2, c0, c1, p0, r0, p1);
    hold(2'b11, 1, c0, c1, p0, r0, p1);
    hold(2'b10, 15, c0, c1, p0, r0, p1);
    check("settle_latency", 32'(c0), 32'(DC + 2));
    check("settle_count",   32'(p0), 32'(1));
    hold(2'b11, 12, c0, c1, p0, r0, p1);

    // Both channels pressed on the same edge.
    hold(2'b00, 12, c0, c1, p0, r0, p1);
    check("simul_ch0", 32'(c0), 32'(DC + 2));
    check("simul_ch1", 32'(c1), 32'(DC + 2));
    check("simul_pulses", 32'(p0 + p1), 32'(2));
    hold(2'b11, 12, c0, c1, p0, r0, p1);

    // Reset part-way through a count, pin held low across release.
    hold(2'b10, 4, c0, c1, p0, r0, p1);
    check("pre_reset_level", 32'(c0), 32'(0));
    do_reset();
    hold(2'b10, 12, c0, c1, p0, r0, p1);
    check("post_reset_latency", 32'(c0), 32'(DC + 2));
    check("post_reset_press",   32'(p0), 32'(1));
    hold(2'b11, 12, c0, c1, p0, r0, p1);

    // Random bouncing per channel with occasional reset.
    pins = 2'b11;
    run_len[0] = 1;
    run_len[1] = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NB; c++) begin
        run_len[c]--;
        if (run_len[c] <= 0) begin
          pins[c] = ~pins[c];
          run_len[c] = int'($urandom_range(1, 3 * DC));
        end
      end
      if ($urandom_range(0, 599) == 0) do_reset();
      step(pins);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter NUM_BUTTONS, default 2, number of independent button channels (>= 1).
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, consecutive clock cycles a changed input must hold before it is accepted (>= 2).
REQ-003 clock  input  1  single system clock; all state is clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 push_button_n  input  NUM_BUTTONS  raw board pins, active-low, asynchronous to clock, may bounce.
REQ-006 push_button  output  NUM_BUTTONS  debounced level, active-high (1 = pressed); registered.
REQ-007 press_pulse  output  NUM_BUTTONS  one-cycle strobe on each debounced 0->1 transition; registered.
REQ-008 release_pulse  output  NUM_BUTTONS  one-cycle strobe on each debounced 1->0 transition; registered.

Function
REQ-009 Each channel SHALL pass push_button_n[i] through a two-flop synchronizer before any other logic uses it.
REQ-010 The sampled level SHALL be the inverted synchronizer output (sample = 1 means pressed).
REQ-011 Each channel SHALL hold a stable register (drives push_button[i]) and a down-count-free up counter of width clog2(DEBOUNCE_CYCLES).
REQ-012 While sample == stable, the counter SHALL be cleared to 0 on every clock.
REQ-013 While sample != stable and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 When sample != stable and counter == DEBOUNCE_CYCLES-1, on that clock: stable <= sample, counter <= 0.
REQ-015 A mismatch lasting fewer than DEBOUNCE_CYCLES consecutive sampled cycles SHALL leave push_button unchanged; any return to agreement restarts the count from 0.
REQ-016 Latency: a clean pin transition first captured at edge N SHALL appear on push_button after edge N+DEBOUNCE_CYCLES+1 (DEBOUNCE_CYCLES+2 edges total including the capture edge).
REQ-017 press_pulse[i] SHALL be 1 for exactly the one cycle in which push_button[i] has just risen, else 0.
REQ-018 release_pulse[i] SHALL be 1 for exactly the one cycle in which push_button[i] has just fallen, else 0.
REQ-019 press_pulse[i] and release_pulse[i] SHALL never be 1 in the same cycle.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each be debounced and pulsed in parallel.
REQ-021 The counter SHALL never wrap; it saturates at DEBOUNCE_CYCLES-1 only for the single cycle before acceptance.

Reset
REQ-022 On reset assertion, asynchronously: synchronizer flops = 1 (released), stable = 0, counter = 0, press_pulse = 0, release_pulse = 0.
REQ-023 Reset asserted mid-count SHALL discard the partial count; no pulse SHALL be emitted by reset itself.
REQ-024 If a button is held through reset release, push_button SHALL rise DEBOUNCE_CYCLES+2 edges after release, accompanied by one press_pulse.

Structure
REQ-025 Package button_pkg SHALL hold the default constants DEFAULT_NUM_BUTTONS = 2 and DEFAULT_DEBOUNCE_CYCLES = 50000.
REQ-026 Per-channel logic (synchronizer, counter, stable, pulses) SHALL be sub-module debounce_channel, instantiated NUM_BUTTONS times via generate.
REQ-027 The block SHALL feed the press-driven state machine directly: push_button or press_pulse connects straight to its button inputs with no extra glue.

Verification (DEBOUNCE_CYCLES = 4, NUM_BUTTONS = 2)
REQ-028 Clean press: push_button_n[0] 1->0 held 20 cycles -> push_button[0] rises 6 edges after first capture; press_pulse[0] high exactly 1 cycle; channel 1 outputs stay 0.
REQ-029 Bounce: push_button_n[0] toggles low 3 cycles, high 1, low 2, high -> push_button[0] stays 0, no pulses.
REQ-030 Bounce then settle: low 2, high 1, then low held -> push_button[0] rises 6 edges after the final low is captured; exactly one press_pulse.
REQ-031 Release: from pressed, push_button_n[0] 0->1 held -> push_button[0] falls after 6 edges; release_pulse[0] 1 cycle; press_pulse stays 0.
REQ-032 Simultaneous: both pins go low on the same cycle -> both push_button bits and both press_pulse bits assert on the same cycle.
REQ-033 Reset mid-operation: assert reset at count 2 with pin held low, release -> all outputs 0 during reset; push_button[0] rises 6 edges after release with one press_pulse.
